// File: rtl/sound_channel_arbiter_if.sv
// Bus bundle for sound_channel_arbiter: per-channel requests/config in, piezo and status out.
// The optional mute input exists only when SOUND_MUTE_EN is defined.
interface sound_channel_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 17,
  parameter int CAD_W  = 26,
  parameter int IDX_W  = 2
);
  logic [NUM_CH-1:0]       ch_req;
  logic [NUM_CH-1:0]       ch_oneshot;
  logic [NUM_CH*DIV_W-1:0] ch_half_period;
  logic [NUM_CH*CAD_W-1:0] ch_on_cycles;
  logic [NUM_CH*CAD_W-1:0] ch_off_cycles;
`ifdef SOUND_MUTE_EN
  logic                    mute;
`endif
  logic                    piezo_out;
  logic                    active_valid;
  logic [IDX_W-1:0]        active_ch;
  logic [NUM_CH-1:0]       ch_sounding;

  modport master (
    output ch_req, ch_oneshot, ch_half_period, ch_on_cycles, ch_off_cycles,
`ifdef SOUND_MUTE_EN
    output mute,
`endif
    input  piezo_out, active_valid, active_ch, ch_sounding
  );

  modport slave (
    input  ch_req, ch_oneshot, ch_half_period, ch_on_cycles, ch_off_cycles,
`ifdef SOUND_MUTE_EN
    input  mute,
`endif
    output piezo_out, active_valid, active_ch, ch_sounding
  );
endinterface

// File: rtl/sound_channel_arbiter.sv
// Multi-channel piezo engine: per-channel cadence FSMs, fixed-priority arbiter, shared tone divider.
// Optional feature macro: SOUND_MUTE_EN (adds a mute input that forces piezo_out low).
module sound_channel_arbiter #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 17,
  parameter int CAD_W  = 26,
  parameter int IDX_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sound_channel_arbiter_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ON = 2'd1, ST_OFF = 2'd2} ch_state_t;

  ch_state_t        r_state [NUM_CH];
  logic [CAD_W-1:0] r_cnt   [NUM_CH];
  logic [CAD_W-1:0] r_n     [NUM_CH];
  logic [CAD_W-1:0] r_m     [NUM_CH];
  logic [DIV_W-1:0] r_h     [NUM_CH];
  logic [NUM_CH-1:0] r_req_d;

  logic [CAD_W-1:0] w_in_n [NUM_CH];
  logic [CAD_W-1:0] w_in_m [NUM_CH];
  logic [DIV_W-1:0] w_in_h [NUM_CH];
  logic [NUM_CH-1:0] w_enter_on, w_enter_off, w_hold, w_sounding;

  // Per-channel transition decode; anything not entering or holding a phase falls to IDLE.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      w_in_n[i]      = bus.ch_on_cycles[i*CAD_W +: CAD_W];
      w_in_m[i]      = bus.ch_off_cycles[i*CAD_W +: CAD_W];
      w_in_h[i]      = bus.ch_half_period[i*DIV_W +: DIV_W];
      w_enter_on[i]  = 1'b0;
      w_enter_off[i] = 1'b0;
      w_hold[i]      = 1'b0;
      w_sounding[i]  = (r_state[i] == ST_ON);
      if (w_in_n[i] == '0 || w_in_h[i] == '0) begin
        w_hold[i] = 1'b0;
      end else if (bus.ch_oneshot[i]) begin
        if (bus.ch_req[i] && !r_req_d[i]) w_enter_on[i] = 1'b1;
        else if (r_state[i] == ST_ON && r_cnt[i] != r_n[i]) w_hold[i] = 1'b1;
      end else if (bus.ch_req[i]) begin
        case (r_state[i])
          ST_ON: begin
            if (r_cnt[i] != r_n[i])     w_hold[i]      = 1'b1;
            else if (w_in_m[i] == '0)   w_enter_on[i]  = 1'b1;
            else                        w_enter_off[i] = 1'b1;
          end
          ST_OFF: begin
            if (r_cnt[i] != r_m[i])     w_hold[i]      = 1'b1;
            else                        w_enter_on[i]  = 1'b1;
          end
          default:                      w_enter_on[i]  = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_d <= '0;
      // NOTE: the per-channel arrays are reset explicitly; their values are visible right after reset.
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i] <= ST_IDLE;
        r_cnt[i]   <= '0;
        r_n[i]     <= '0;
        r_m[i]     <= '0;
        r_h[i]     <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      r_req_d <= bus.ch_req;
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_enter_on[i] || w_enter_off[i]) begin
          r_state[i] <= w_enter_off[i] ? ST_OFF : ST_ON;
          r_cnt[i]   <= CAD_W'(1);
          r_n[i]     <= w_in_n[i];
          r_m[i]     <= w_in_m[i];
          r_h[i]     <= w_in_h[i];
        end else if (w_hold[i]) begin
          r_cnt[i]   <= r_cnt[i] + 1'b1;
        end else begin
          r_state[i] <= ST_IDLE;
          r_cnt[i]   <= '0;
        end
      end
    end
  end

  logic             w_win_valid;
  logic [IDX_W-1:0] w_win_idx;
  logic [DIV_W-1:0] w_tc_nxt;
  logic             w_wave_nxt;
  logic             r_valid;
  logic [IDX_W-1:0] r_ch;
  logic [DIV_W-1:0] r_tc;
  logic             r_wave;

  // Lowest-index ON channel wins; a new winner restarts the tone phase from zero.
  always_comb begin
    w_win_valid = |w_sounding;
    w_win_idx   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_sounding[i]) w_win_idx = IDX_W'(i);
    end
    w_tc_nxt   = '0;
    w_wave_nxt = 1'b0;
    if (w_win_valid && r_valid && (w_win_idx == r_ch)) begin
      if (r_tc == r_h[w_win_idx]) begin
        w_wave_nxt = ~r_wave;
      end else begin
        w_tc_nxt   = r_tc + 1'b1;
        w_wave_nxt = r_wave;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_ch    <= '0;
      r_tc    <= '0;
      r_wave  <= 1'b0;
    end else begin
      r_valid <= w_win_valid;
      r_ch    <= w_win_idx;
      r_tc    <= w_tc_nxt;
      r_wave  <= w_wave_nxt;
    end
  end

`ifdef SOUND_MUTE_EN
  logic r_piezo;

  // Muting only gates the pin; cadence and tone counters keep running in phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_piezo <= 1'b0;
    else        r_piezo <= w_wave_nxt & ~bus.mute;
  end

  assign bus.piezo_out = r_piezo;
`else
  assign bus.piezo_out = r_wave;
`endif

  assign bus.active_valid = r_valid;
  assign bus.active_ch    = r_ch;
  assign bus.ch_sounding  = w_sounding;

endmodule

// File: tb/tb_sound_channel_arbiter.sv
// Scoreboard bench for sound_channel_arbiter: directed scenarios plus randomized segments
// checked against a countdown/elapsed-time reference model.
module tb_sound_channel_arbiter;
  localparam int NUM_CH = 4;
  localparam int DIV_W  = 17;
  localparam int CAD_W  = 26;
  localparam int IDX_W  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sound_channel_arbiter_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .CAD_W(CAD_W), .IDX_W(IDX_W)) bus ();

  sound_channel_arbiter #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .CAD_W(CAD_W), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit valid;
    int ch;
    int snd;
    bit piezo;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  int cfg_h [NUM_CH];
  int cfg_n [NUM_CH];
  int cfg_m [NUM_CH];

  // Reference model: phase flags, cycles left in the phase, and cycles elapsed under one winner.
  bit m_on   [NUM_CH];
  bit m_off  [NUM_CH];
  int m_left [NUM_CH];
  int m_lh   [NUM_CH];
  bit m_prev [NUM_CH];
  int m_win;
  int m_age;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
  endtask

  task automatic set_cfg(input int i, input int h, input int n, input int m);
    cfg_h[i] = h;
    cfg_n[i] = n;
    cfg_m[i] = m;
    bus.ch_half_period[i*DIV_W +: DIV_W] = DIV_W'(h);
    bus.ch_on_cycles[i*CAD_W +: CAD_W]   = CAD_W'(n);
    bus.ch_off_cycles[i*CAD_W +: CAD_W]  = CAD_W'(m);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic idle_all();
    bus.ch_req     = '0;
    bus.ch_oneshot = '0;
    tick(3);
  endtask

  task automatic start_phase(input int i, input bit is_on, input int len);
    m_on[i]   = is_on;
    m_off[i]  = !is_on;
    m_left[i] = len;
    m_lh[i]   = cfg_h[i];
  endtask

  task automatic model_step();
    int  w;
    bit  wave;
    bit  mute_now;
    int  snd;
    exp_t e;
    w = -1;
    for (int i = NUM_CH - 1; i >= 0; i--) if (m_on[i]) w = i;
    if (w < 0 || w != m_win) m_age = 0;
    else m_age++;
    wave  = (w >= 0) && (((m_age / (m_lh[w] + 1)) % 2) == 1);
    m_win = w;
    for (int i = 0; i < NUM_CH; i++) begin
      bit req;
      bit rise;
      req  = bus.ch_req[i];
      rise = req && !m_prev[i];
      if (cfg_n[i] == 0 || cfg_h[i] == 0) begin
        m_on[i] = 0; m_off[i] = 0;
      end else if (bus.ch_oneshot[i]) begin
        if (rise) start_phase(i, 1'b1, cfg_n[i]);
        else if (m_on[i] && m_left[i] > 1) m_left[i]--;
        else begin m_on[i] = 0; m_off[i] = 0; end
      end else if (!req) begin
        m_on[i] = 0; m_off[i] = 0;
      end else if (m_on[i]) begin
        if (m_left[i] > 1) m_left[i]--;
        else if (cfg_m[i] == 0) start_phase(i, 1'b1, cfg_n[i]);
        else start_phase(i, 1'b0, cfg_m[i]);
      end else if (m_off[i]) begin
        if (m_left[i] > 1) m_left[i]--;
        else start_phase(i, 1'b1, cfg_n[i]);
      end else begin
        start_phase(i, 1'b1, cfg_n[i]);
      end
      m_prev[i] = req;
    end
    snd = 0;
    for (int i = 0; i < NUM_CH; i++) if (m_on[i]) snd |= (1 << i);
`ifdef SOUND_MUTE_EN
    mute_now = bus.mute;
`else
    mute_now = 1'b0;
`endif
    e.valid = (w >= 0);
    e.ch    = (w >= 0) ? w : 0;
    e.snd   = snd;
    e.piezo = wave && !mute_now;
    exp_q.push_back(e);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_on[i] = 0; m_off[i] = 0; m_left[i] = 0; m_lh[i] = 0; m_prev[i] = 0;
      end
      m_win = -1;
      m_age = 0;
      exp_q.delete();
      exp_q.push_back('{1'b0, 0, 0, 1'b0});
    end else begin
      model_step();
    end
  end

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("active_valid", 32'(bus.active_valid), 32'(e.valid));
      check("active_ch",    32'(bus.active_ch),    32'(e.ch));
      check("ch_sounding",  32'(bus.ch_sounding),  32'(e.snd));
      check("piezo_out",    32'(bus.piezo_out),    32'(e.piezo));
    end
  end

  initial begin
    bus.ch_req     = '0;
    bus.ch_oneshot = '0;
    bus.ch_half_period = '0;
    bus.ch_on_cycles   = '0;
    bus.ch_off_cycles  = '0;
`ifdef SOUND_MUTE_EN
    bus.mute = 1'b0;
`endif
    for (int i = 0; i < NUM_CH; i++) set_cfg(i, 3, 5, 2);

    // Requests held high through reset re-enter ON at the first edge after release.
    bus.ch_req = '1;
    tick(4);
    rst_n = 1'b1;
    tick(12);
    idle_all();

    set_cfg(2, 4, 20, 10);
    bus.ch_req[2] = 1'b1;
    tick(100);
    bus.ch_req[2] = 1'b0;
    tick(4);

    set_cfg(1, 2, 8, 0);
    bus.ch_req[1] = 1'b1;
    tick(60);
    bus.ch_req[1] = 1'b0;
    tick(4);

    set_cfg(1, 5, 30, 5);
    bus.ch_oneshot[1] = 1'b1;
    bus.ch_req[1] = 1'b1;
    tick(1);
    bus.ch_req[1] = 1'b0;
    tick(19);
    bus.ch_req[1] = 1'b1;
    tick(80);
    idle_all();

    set_cfg(3, 9, 40, 0);
    set_cfg(0, 3, 15, 5);
    bus.ch_req[3] = 1'b1;
    tick(27);
    bus.ch_req[0] = 1'b1;
    tick(15);
    bus.ch_req[0] = 1'b0;
    tick(30);

    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(20);
    idle_all();

`ifdef SOUND_MUTE_EN
    set_cfg(2, 4, 20, 10);
    bus.ch_req[2] = 1'b1;
    tick(17);
    bus.mute = 1'b1;
    tick(37);
    bus.mute = 1'b0;
    tick(30);
    idle_all();
`endif

    repeat (12) begin
      idle_all();
      for (int i = 0; i < NUM_CH; i++)
        set_cfg(i, $urandom_range(0, 9), $urandom_range(0, 25), $urandom_range(0, 15));
      bus.ch_oneshot = NUM_CH'($urandom_range(0, (1 << NUM_CH) - 1));
      tick(1);
      repeat (150) begin
        for (int i = 0; i < NUM_CH; i++)
          if ($urandom_range(0, 7) == 0) bus.ch_req[i] = ~bus.ch_req[i];
`ifdef SOUND_MUTE_EN
        if ($urandom_range(0, 15) == 0) bus.mute = ~bus.mute;
`endif
        tick(1);
      end
    end
    idle_all();
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/sound_channel_arbiter.md
# sound_channel_arbiter

Parametrised multi-channel piezo sound engine: the next generation of the vehicle sound unit. Each of NUM_CH channels runs its own cadence state machine (beep on/off pattern or one-shot burst) with a per-channel tone divider supplied at run time. A fixed-priority arbiter selects one sounding channel, and a shared square-wave generator drives the piezo. The block sits between the car control logic (horn, reverse, turn signal, warnings) and the board's piezo pin.

## Interface
- NUM_CH, 4: number of channels; channel 0 has the highest priority.
- DIV_W, 17: width of each tone half-period field.
- CAD_W, 26: width of each cadence on/off field.
- IDX_W, 2: width of active_ch; must satisfy 2^IDX_W >= NUM_CH.

- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- ch_req  in  NUM_CH  per-channel request; a level in level mode, a trigger in one-shot mode.
- ch_oneshot  in  NUM_CH  per-channel mode: 1 = one-shot on rising edge, 0 = level/cadence.
- ch_half_period  in  NUM_CH*DIV_W  packed tone half-period H; channel i occupies [i*DIV_W +: DIV_W].
- ch_on_cycles  in  NUM_CH*CAD_W  packed ON length N.
- ch_off_cycles  in  NUM_CH*CAD_W  packed OFF length M.
- piezo_out  out  1  square-wave output, registered.
- active_valid  out  1  a channel currently owns the output.
- active_ch  out  IDX_W  index of the owning channel; 0 when active_valid = 0.
- ch_sounding  out  NUM_CH  per-channel "state == ON" flags.

## Operation
- Each channel has three states: IDLE, ON and OFF. A channel is masked (held in IDLE) while its N == 0 or its H == 0.
- Level mode:
  - IDLE goes to ON when ch_req = 1.
  - ON goes to OFF after N cycles, or restarts ON when M == 0 (continuous tone).
  - OFF goes to ON after M cycles.
  - ch_req = 0 sends the channel to IDLE on the next edge from any state.
- One-shot mode:
  - A rising edge of ch_req (against a registered copy of ch_req) moves any state to ON and reloads N.
  - ON goes to IDLE after N cycles. OFF is never used.
  - The level of ch_req is otherwise ignored.
  - Both edges of a toggling input are supported only by the caller pulsing ch_req.
- N, M and H are latched into per-channel registers on entry to ON or OFF. Changes made mid-phase take effect at the next phase entry.
- Arbiter: the winner is the lowest index with state ON.
- Tone generator: counter tc runs from 0 to H_winner; at tc == H_winner it clears and wave toggles. Half period is H+1 cycles, so a 50 MHz clock with H = 24999 gives a 1 kHz tone.
- On any change of winner, including valid going 0 to 1, tc and wave clear to 0 on the same edge. This is a phase restart with no runt pulse from the old channel.
- When there is no winner, wave = 0 and tc = 0.
- piezo_out equals the wave register.

## Timing
- Reset values: piezo_out = 0, active_valid = 0, active_ch = 0, ch_sounding = 0. All channels are IDLE, all counters are 0, and the edge-detect registers are 0.
- Let E0 be the edge that samples the request. At E0 the channel enters ON and ch_sounding[i] = 1.
- At E1: active_valid = 1, active_ch = i, tc = 0, wave = 0.
- First piezo_out rise is at edge E1 + H + 1.
- ON lasts exactly N cycles (E0 to E0+N). active_valid or active_ch update one cycle after ch_sounding changes.
- Simultaneous events:
  - Level-mode ch_req drop in the same cycle as ON expiry: IDLE wins.
  - One-shot retrigger in the same cycle as ON expiry: restart ON with N reloaded.
  - Several channels entering ON on one edge: the lowest index wins at E1.
- Counter wrap: cadence and tone counters never wrap. They compare against latched values with equality and clear on reaching them.
- rst_n asserted mid-tone: all outputs go to reset values immediately (asynchronous). After release, a level-mode request still high re-enters ON on the first clock edge.

## Configuration
- SOUND_MUTE_EN defined:
  - Adds an input port mute (1 bit).
  - While mute = 1, piezo_out is forced to 0 by its register.
  - Channel state machines, the arbiter and tc keep running, so unmuting resumes mid-cadence in phase.
- SOUND_MUTE_EN undefined: no mute port, and piezo_out always equals wave.

## Test plan
- Reset: hold rst_n = 0 with ch_req = all ones, then release. Required: all outputs 0 during reset; ch_sounding = 4'b1111 after the first edge; active_ch = 0 one cycle later.
- Level cadence: ch2 with H = 4, N = 20, M = 10, ch_req[2] high for 100 cycles. Required: piezo_out toggles every 5 cycles during ON; active_valid follows the 20/10 pattern delayed one cycle; active_valid = 0 within 2 cycles of the request drop.
- Continuous tone: M = 0, N = 8, H = 2. Required: ch_sounding stays 1 continuously, and piezo_out is an unbroken period-6 square wave across the N reloads.
- One-shot retrigger: ch1 in one-shot mode, N = 30, pulse ch_req[1] at t = 0 and t = 20. Required: ON lasts 50 cycles in total, then IDLE; holding ch_req high produces no further bursts.
- Preemption: ch3 sounding with H = 9; ch0 requested with H = 3 at cycle k. Required: at k+2, active_ch = 0, wave = 0, tc = 0; first rise at k+6; ch3 resumes with wave = 0 after ch0 ends.
- Mute (SOUND_MUTE_EN defined): mute = 1 during a level cadence. Required: piezo_out = 0 while the ON/OFF timing of ch_sounding is unchanged; after mute falls, piezo_out continues in phase with tc.
